// File: rtl/fir_sample_serializer.sv
// fir_sample_serializer
// Captures 16-bit FIR output samples into a small FIFO and streams each one
// out as two bytes over an 8-bit valid/ready link, with out_last marking the
// second byte of every sample. Data passes through bit-exact.
module fir_sample_serializer #(
    parameter int DATA_W    = 16,   // must equal 2*BYTE_W
    parameter int BYTE_W    = 8,
    parameter int DEPTH     = 4,    // power of 2, >= 2
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          y_dat,
    input  logic                       y_vld,
    output logic [BYTE_W-1:0]          out_byte,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    // Sample storage; no reset so it maps onto distributed/block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [LVL_W-1:0]  level_next;
    logic              overflow_reg;

    state_t            state_reg;
    state_t            state_next;
    logic              pop;
    logic              push;

    logic [BYTE_W-1:0] out_byte_reg;
    logic [BYTE_W-1:0] second_reg;      // byte still owed for the held sample
    logic              out_valid_reg;
    logic              out_last_reg;

    logic [DATA_W-1:0] rd_word;
    logic [BYTE_W-1:0] rd_lane [2];
    logic [BYTE_W-1:0] first_lane;
    logic [BYTE_W-1:0] other_lane;

    assign rd_word = mem[rd_ptr_reg];

    // Split the head-of-FIFO word into its byte lanes (lane 0 = low byte).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign rd_lane[gi] = rd_word[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    assign first_lane = (MSB_FIRST != 0) ? rd_lane[1] : rd_lane[0];
    assign other_lane = (MSB_FIRST != 0) ? rd_lane[0] : rd_lane[1];

    // A full FIFO still takes a sample when the head leaves on the same edge.
    assign push = y_vld && ((level_reg < LVL_W'(DEPTH)) || pop);

    // Occupancy bookkeeping: simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // Next-state logic; pop happens only when a sample is loaded for output.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (level_reg != '0) begin
                    pop        = 1'b1;
                    state_next = FIRST;
                end
            end
            FIRST: begin
                if (out_ready) begin
                    state_next = SECOND;
                end
            end
            SECOND: begin
                if (out_ready) begin
                    if (level_reg != '0) begin
                        pop        = 1'b1;
                        state_next = FIRST;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FIFO write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= y_dat;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_next;
            if (y_vld && !push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // State register and registered link outputs; bytes only change on load or acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            out_byte_reg  <= '0;
            second_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= (state_next != IDLE);
            out_last_reg  <= (state_next == SECOND);
            if (pop) begin
                out_byte_reg <= first_lane;
                second_reg   <= other_lane;
            end else if ((state_reg == FIRST) && out_ready) begin
                out_byte_reg <= second_reg;
            end
        end
    end

    assign out_byte  = out_byte_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign level     = level_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_fir_sample_serializer.sv
// Bench for fir_sample_serializer: a byte-stream model (queue of samples plus
// count of bytes still owed for the sample being sent) is checked against the
// DUT every cycle, plus directed scenarios with hand-computed values.
module tb_fir_sample_serializer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [15:0] y_dat;
    logic        y_vld;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [2:0]  level;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    fir_sample_serializer #(
        .DATA_W(16), .BYTE_W(8), .DEPTH(DEPTH), .MSB_FIRST(1)
    ) dut (
        .clk(clk), .rst(rst), .y_dat(y_dat), .y_vld(y_vld),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .level(level), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_q[$];
    logic [15:0] m_cur;
    int          m_busy;     // bytes of m_cur still to be delivered (0..2)
    bit          m_ovf;

    initial begin
        m_busy = 0;
        m_ovf  = 0;
        m_cur  = '0;
    end

    always @(posedge clk) begin
        int  sz;
        bit  acc, pp, ps;
        if (rst) begin
            m_q.delete();
            m_busy = 0;
            m_ovf  = 0;
        end else begin
            acc = (m_busy > 0) && out_ready;
            sz  = m_q.size();
            pp  = (sz > 0) && ((m_busy == 0) || (m_busy == 1 && acc));
            ps  = y_vld && ((sz < DEPTH) || pp);
            if (y_vld && !ps) m_ovf = 1;
            if (acc) begin
                $display("xfer byte=%02h last=%0d", (m_busy == 2) ? m_cur[15:8] : m_cur[7:0], (m_busy == 1));
                m_busy--;
            end
            if (pp) begin
                m_cur  = m_q.pop_front();
                m_busy = 2;
            end
            if (ps) m_q.push_back(y_dat);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("valid", out_valid, (m_busy > 0));
        chk("level", level, m_q.size());
        chk("overflow", overflow, m_ovf);
        if (m_busy > 0) begin
            chk("byte", out_byte, (m_busy == 2) ? m_cur[15:8] : m_cur[7:0]);
            chk("last", out_last, (m_busy == 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] got_b [16];
    logic [7:0] exp_b [10];
    int         got;

    initial begin
        rst = 1'b1; y_vld = 1'b1; y_dat = 16'h1234; out_ready = 1'b1;

        // T1: reset held with strobes present
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t1_valid", out_valid, 0);
            chk("t1_level", level, 0);
            chk("t1_ovf", overflow, 0);
        end
        rst = 1'b0; y_vld = 1'b0;

        // T2: single sample, latency and byte order
        y_vld = 1'b1; y_dat = 16'hA55A;
        step();                         // E0 captures
        y_vld = 1'b0;
        chk("t2_e0_valid", out_valid, 0);
        chk("t2_e0_level", level, 1);
        step();                         // E1 pops
        chk("t2_b0_valid", out_valid, 1);
        chk("t2_b0_byte", out_byte, 8'hA5);
        chk("t2_b0_last", out_last, 0);
        chk("t2_b0_level", level, 0);
        step();
        chk("t2_b1_byte", out_byte, 8'h5A);
        chk("t2_b1_last", out_last, 1);
        step();
        chk("t2_idle", out_valid, 0);

        // T3: backpressure during FIRST
        out_ready = 1'b0;
        y_vld = 1'b1; y_dat = 16'hA55A;
        step();
        y_vld = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_byte", out_byte, 8'hA5);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("t3_rel_byte", out_byte, 8'h5A);
        chk("t3_rel_last", out_last, 1);
        step();
        chk("t3_idle", out_valid, 0);

        // T4: overrun with stalled output
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            y_vld = 1'b1; y_dat = 16'h1000 + 16'(i);
            step();
        end
        y_vld = 1'b0;
        chk("t4_level", level, 4);
        chk("t4_ovf", overflow, 1);
        chk("t4_byte", out_byte, 8'h10);
        chk("model_t4_level", m_q.size(), 4);
        out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && got < 10; k++) begin
            if (out_valid) begin
                got_b[got] = out_byte;
                got++;
            end
            step();
        end
        chk("t4_count", got, 10);
        for (int i = 0; i < 5; i++) begin
            exp_b[2*i]   = 8'h10;
            exp_b[2*i+1] = 8'(i);
        end
        for (int i = 0; i < 10 && i < got; i++) chk("t4_order", got_b[i], exp_b[i]);
        chk("t4_empty", out_valid, 0);

        // T5: full FIFO, pop and push on the same edge
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            y_vld = 1'b1; y_dat = 16'h2000 + 16'(i);
            step();
        end
        y_vld = 1'b0;
        chk("t5_full", level, 4);
        chk("t5_ovf0", overflow, 0);
        out_ready = 1'b1;
        step();                         // FIRST accepted -> SECOND
        chk("t5_second", out_last, 1);
        y_vld = 1'b1; y_dat = 16'hBEEF;
        step();                         // pop + push together
        y_vld = 1'b0;
        chk("t5_level", level, 4);
        chk("t5_ovf", overflow, 0);
        chk("t5_byte", out_byte, 8'h20);

        // T6: reset while in SECOND with level 3
        step();                         // SECOND, level 4
        step();                         // pop -> FIRST, level 3
        step();                         // SECOND, level 3
        chk("t6_pre_last", out_last, 1);
        chk("t6_pre_level", level, 3);
        out_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", out_valid, 0);
        chk("t6_level", level, 0);
        out_ready = 1'b1;
        y_vld = 1'b1; y_dat = 16'h0102;
        step();
        y_vld = 1'b0;
        step();
        chk("t6_b0", out_byte, 8'h01);
        step();
        chk("t6_b1", out_byte, 8'h02);
        chk("t6_b1_last", out_last, 1);
        step();
        chk("t6_idle", out_valid, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
